// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl
// Brief   : Byte-addressable RV32 data memory with valid/ready request port,
//           configurable read latency, fault reporting and post-reset clear.
// Revision: 1.0
// ============================================================================
module dmem_ctrl #(
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_access,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic        busy
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** WA;
  localparam logic [1:0] c_LAT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_CLEAR     = 2'd0,
    S_IDLE      = 2'd1,
    S_LOAD_WAIT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [WA-1:0]  clr_cnt_q, clr_cnt_d;
  logic [1:0]     lat_q, lat_d;
  logic [31:0]    ld_data_q, ld_data_d;
  logic           ld_fault_q, ld_fault_d;
  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_data_q, resp_data_d;
  logic           resp_fault_q, resp_fault_d;
  logic [31:0]    mem_q [WORDS];

  logic           w_accept;
  logic           w_fault;
  logic [WA-1:0]  w_widx;
  logic [31:0]    w_rword;
  logic [31:0]    w_shift;
  logic [31:0]    w_ldata;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata;
  logic           w_st_we;
  logic           w_clr_we;

  assign req_ready  = !rst && ((state_q == S_IDLE) ||
                               (state_q == S_LOAD_WAIT && resp_valid_q));
  assign busy       = rst || (state_q == S_CLEAR) ||
                      (state_q == S_LOAD_WAIT && !resp_valid_q);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;

  assign w_accept = req_valid && req_ready;
  assign w_widx   = req_addr[ADDR_WIDTH-1:2];
  assign w_rword  = mem_q[w_widx];
  assign w_shift  = w_rword >> {req_addr[1:0], 3'b000};

  assign w_fault = (|req_addr[31:ADDR_WIDTH])
                 || (req_access == 3'b011) || (req_access == 3'b110) || (req_access == 3'b111)
                 || (req_access[1:0] == 2'b01 && req_addr[0])
                 || (req_access[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
                 || (req_store && req_access[2]);

  always_comb begin
    w_ldata = '0;
    case (req_access)
      3'b000:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_ldata = w_rword;
      3'b100:  w_ldata = {24'd0, w_shift[7:0]};
      3'b101:  w_ldata = {16'd0, w_shift[15:0]};
      default: w_ldata = '0;
    endcase
    if (w_fault) w_ldata = '0;
  end

  // Store data is replicated across lanes so the byte-enable alone picks the target bytes.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    case (req_access[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << req_addr[1:0];
        w_wdata = {2{req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_st_we  = w_accept && req_store && !w_fault;
  assign w_clr_we = (state_q == S_CLEAR) && CLEAR_ON_RESET && !rst;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    lat_d        = lat_q;
    ld_data_d    = ld_data_q;
    ld_fault_d   = ld_fault_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;

    case (state_q)
      S_CLEAR: begin
        if (!CLEAR_ON_RESET || clr_cnt_q == {WA{1'b1}}) state_d = S_IDLE;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end
      S_LOAD_WAIT: begin
        if (resp_valid_q) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 2'd1;
          if (lat_q == 2'd1) begin
            resp_valid_d = 1'b1;
            resp_data_d  = ld_data_q;
            resp_fault_d = ld_fault_q;
          end
        end
      end
      default: ;
    endcase

    // Accept only happens when no response is being generated above.
    if (w_accept) begin
      if (req_store) begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_data_d  = '0;
        resp_fault_d = w_fault;
      end else begin
        state_d    = S_LOAD_WAIT;
        ld_data_d  = w_ldata;
        ld_fault_d = w_fault;
        lat_d      = c_LAT_INIT;
        if (READ_LATENCY == 1) begin
          resp_valid_d = 1'b1;
          resp_data_d  = w_ldata;
          resp_fault_d = w_fault;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      lat_q        <= '0;
      ld_data_q    <= '0;
      ld_fault_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      lat_q        <= lat_d;
      ld_data_q    <= ld_data_d;
      ld_fault_q   <= ld_fault_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Storage array is deliberately not reset so contents survive when clearing is disabled.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (w_st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_ctrl
// Brief   : Self-checking bench for dmem_ctrl against a byte-array model.
// Revision: 1.0
// ============================================================================
module tb_dmem_ctrl;

  localparam int AW = 6;
  localparam int RL = 3;
  localparam int NB = 1 << AW;
  localparam int NW = NB / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_access;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        busy;

  dmem_ctrl #(
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (RL),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_access(req_access),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_fault(resp_fault),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mb [NB];
  int checks   = 0;
  int failures = 0;
  int last_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] a);
    case (a)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_fault(input bit st, input logic [2:0] a, input logic [31:0] ad);
    int s = sz(a);
    if (s == 0) return 1'b1;
    if (ad >= 32'(NB)) return 1'b1;
    if ((ad % 32'(s)) != 0) return 1'b1;
    if (st && a[2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] a, input logic [31:0] ad);
    logic [31:0] v = '0;
    int s = sz(a);
    for (int i = 0; i < s; i++) v |= 32'(mb[ad + 32'(i)]) << (8 * i);
    if (!a[2] && s < 4 && v[8*s-1]) v |= 32'hFFFF_FFFF << (8 * s);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
  endtask

  task automatic txn(input bit st, input logic [2:0] a, input logic [31:0] ad,
                     input logic [31:0] wd, input string tag);
    int n;
    int lowc;
    bit f;
    logic [31:0] exp;
    f   = m_fault(st, a, ad);
    exp = '0;
    if (!st && !f) exp = m_load(a, ad);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!req_ready) begin
      chk({tag, " ready_timeout"}, {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_store  = st;
    req_access = a;
    req_addr   = ad;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_access = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    n    = 1;
    lowc = 0;
    while (!resp_valid && n < 50) begin
      if (!req_ready) lowc++;
      @(negedge clk);
      n++;
    end
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " latency"}, n, st ? 1 : RL);
    chk({tag, " data"}, resp_data, exp);
    chk({tag, " fault"}, {31'd0, resp_fault}, {31'd0, f});
    chk({tag, " ready_in_resp"}, {31'd0, req_ready}, 32'd1);
    if (!st) chk({tag, " ready_low_cycles"}, lowc, RL - 1);
    if (st && !f) begin
      for (int i = 0; i < sz(a); i++) mb[ad + 32'(i)] = wd[8*i +: 8];
    end
  endtask

  task automatic do_reset(input int hold);
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (hold) @(negedge clk);
    chk("rst ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd1);
    chk("rst resp_data", resp_data, 32'd0);
    chk("rst resp_fault", {31'd0, resp_fault}, 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, NW);
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [2:0] acc_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_access = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    last_wait  = 0;
    repeat (2) @(negedge clk);

    do_reset(2);
    wait_clear("clear_first");
    for (int w = 0; w < NW; w++) txn(1'b1, 3'b010, 32'(w * 4), $urandom | 32'd1, "preload");

    do_reset(2);
    wait_clear("clear_len");
    for (int w = 0; w < NW; w++) txn(1'b0, 3'b010, 32'(w * 4), '0, "lw_zero");

    txn(1'b1, 3'b010, 32'h10, 32'h8BAD_F00D, "sw10");
    txn(1'b0, 3'b000, 32'h13, '0, "lb13");
    chk("lb13 const", resp_data, 32'hFFFF_FF8B);
    txn(1'b0, 3'b100, 32'h13, '0, "lbu13");
    chk("lbu13 const", resp_data, 32'h0000_008B);
    txn(1'b0, 3'b001, 32'h12, '0, "lh12");
    chk("lh12 const", resp_data, 32'hFFFF_8BAD);
    txn(1'b0, 3'b101, 32'h10, '0, "lhu10");
    chk("lhu10 const", resp_data, 32'h0000_F00D);

    txn(1'b1, 3'b010, 32'h20, 32'h1122_3344, "sw20");
    txn(1'b1, 3'b000, 32'h21, 32'hFFFF_FF5A, "sb21");
    txn(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, "sh22");
    txn(1'b0, 3'b010, 32'h20, '0, "lw20");
    chk("lw20 const", resp_data, 32'hBEEF_5A44);

    txn(1'b1, 3'b010, 32'h11, 32'hDEAD_BEEF, "sw11_fault");
    chk("sw11 fault const", {31'd0, resp_fault}, 32'd1);
    txn(1'b0, 3'b001, 32'h03, '0, "lh03_fault");
    txn(1'b1, 3'b000, 32'(NB), 32'h0000_00AA, "sb_oor_fault");
    txn(1'b0, 3'b011, 32'h10, '0, "acc011_fault");
    chk("acc011 fault const", {31'd0, resp_fault}, 32'd1);
    txn(1'b1, 3'b100, 32'h10, 32'h0000_0077, "sbu_store_fault");
    txn(1'b0, 3'b010, 32'h10, '0, "lw10_after_faults");
    chk("lw10 unchanged const", resp_data, 32'h8BAD_F00D);

    txn(1'b0, 3'b010, 32'h10, '0, "b2b_first");
    txn(1'b0, 3'b010, 32'h20, '0, "b2b_second");
    chk("b2b no wait", last_wait, 0);

    // Requests during clear must be ignored; reset mid-clear restarts the sweep.
    do_reset(2);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_access = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'hFFFF_FFFF;
    repeat (5) begin
      @(negedge clk);
      chk("clear ignores req", {31'd0, resp_valid}, 32'd0);
    end
    req_valid = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    wait_clear("clear_restart");
    txn(1'b0, 3'b010, 32'h0, '0, "lw0_after_ignored");

    txn(1'b1, 3'b010, 32'h10, 32'hCAFE_0001, "sw10_pre_rst");
    while (!req_ready) @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_access = 3'b010;
    req_addr   = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("load rst no resp", {31'd0, resp_valid}, 32'd0);
      chk("load rst busy", {31'd0, busy}, 32'd1);
    end
    rst = 1'b0;
    model_clear();
    wait_clear("clear_after_load_rst");
    txn(1'b0, 3'b010, 32'h10, '0, "lw10_after_rst");

    for (int k = 0; k < 300; k++) begin
      bit          st;
      logic [2:0]  a;
      logic [31:0] ad;
      int          r;
      st = 1'($urandom);
      a  = acc_tab[$urandom_range(0, 7)];
      r  = $urandom_range(0, 9);
      if (r == 0)      ad = $urandom;
      else if (r == 1) ad = 32'(NB) + 32'($urandom_range(0, 63));
      else begin
        ad = 32'($urandom_range(0, NB - 1));
        if (r > 4 && sz(a) > 1) ad = ad & ~(32'(sz(a)) - 32'd1);
      end
      txn(st, a, ad, $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
